// File: rtl/mem_wb_pkg.sv
// Shared constants and types for the MEM/WB pipeline register.
// Holds stall bit positions, enable encodings and the WB payload bundle.
package mem_wb_pkg;

    localparam int unsigned REG_BUS_W      = 32;
    localparam int unsigned REG_ADDR_BUS_W = 5;
    localparam int unsigned STALL_W        = 6;
    localparam int unsigned STALL_MEM      = 4;
    localparam int unsigned STALL_WB       = 5;

    localparam logic [REG_BUS_W-1:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic                 WRITE_ENABLE  = 1'b1;
    localparam logic                 WRITE_DISABLE = 1'b0;
    localparam logic                 RST_ENABLE    = 1'b1;

    typedef enum logic [1:0] {
        ACT_FLUSH   = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_CAPTURE = 2'd2,
        ACT_HOLD    = 2'd3
    } pipe_action_e;

    typedef struct packed {
        logic [REG_ADDR_BUS_W-1:0] wd;
        logic                      wreg;
        logic [REG_BUS_W-1:0]      wdata;
        logic                      whilo;
        logic [REG_BUS_W-1:0]      hi;
        logic [REG_BUS_W-1:0]      lo;
        logic                      llbit_we;
        logic                      llbit_value;
    } wb_bundle_t;

    localparam wb_bundle_t WB_BUBBLE = '{
        wd:          5'd0,
        wreg:        WRITE_DISABLE,
        wdata:       ZERO_WORD,
        whilo:       WRITE_DISABLE,
        hi:          ZERO_WORD,
        lo:          ZERO_WORD,
        llbit_we:    WRITE_DISABLE,
        llbit_value: 1'b0
    };

    // Non-reset priority: flush, then bubble (MEM stalled, WB free), capture, hold.
    function automatic pipe_action_e pipe_action(input logic flush,
                                                 input logic [STALL_W-1:0] stall);
        pipe_action_e act;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (stall[STALL_MEM] && !stall[STALL_WB]) begin
            act = ACT_BUBBLE;
        end else if (!stall[STALL_MEM]) begin
            act = ACT_CAPTURE;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/mem_wb_if.sv
// MEM->WB bundle: MEM-side inputs, pipeline control and WB-side results.
interface mem_wb_if;
    import mem_wb_pkg::*;

    logic [STALL_W-1:0]        stall;
    logic                      flush;
    logic [REG_ADDR_BUS_W-1:0] mem_wd;
    logic                      mem_wreg;
    logic [REG_BUS_W-1:0]      mem_wdata;
    logic                      mem_whilo;
    logic [REG_BUS_W-1:0]      mem_hi;
    logic [REG_BUS_W-1:0]      mem_lo;
    logic                      mem_llbit_we;
    logic                      mem_llbit_value;
    logic [REG_ADDR_BUS_W-1:0] wb_wd;
    logic                      wb_wreg;
    logic [REG_BUS_W-1:0]      wb_wdata;
    logic                      wb_whilo;
    logic [REG_BUS_W-1:0]      wb_hi;
    logic [REG_BUS_W-1:0]      wb_lo;
    logic                      wb_llbit_we;
    logic                      wb_llbit_value;
    logic                      llbit_o;

    modport master (
        output stall, flush, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
               mem_llbit_we, mem_llbit_value,
        input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
               wb_llbit_we, wb_llbit_value, llbit_o
    );

    modport slave (
        input  stall, flush, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
               mem_llbit_we, mem_llbit_value,
        output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
               wb_llbit_we, wb_llbit_value, llbit_o
    );

endinterface

// File: rtl/mem_wb_llbit_reg.sv
// Load-linked bit register; cleared by reset or flush, written from the WB stage.
module llbit_reg
    import mem_wb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic we,
    input  logic din,
    output logic dout
);

    // LL bit state: flush always wins over a pending write.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            dout <= 1'b0;
        end else if (flush) begin
            dout <= 1'b0;
        end else if (we == WRITE_ENABLE) begin
            dout <= din;
        end else begin
            dout <= dout;
        end
    end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with flush/stall handling and forwarded LL bit.
module mem_wb
    import mem_wb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    mem_wb_if.slave  bus
);

    wb_bundle_t   mem_s;
    wb_bundle_t   wb_r;
    pipe_action_e act_s;
    logic         llbit_s;
    logic         llbit_o_s;

    // Pack MEM-side inputs and decode this cycle's pipeline action.
    always_comb begin
        mem_s = '{
            wd:          bus.mem_wd,
            wreg:        bus.mem_wreg,
            wdata:       bus.mem_wdata,
            whilo:       bus.mem_whilo,
            hi:          bus.mem_hi,
            lo:          bus.mem_lo,
            llbit_we:    bus.mem_llbit_we,
            llbit_value: bus.mem_llbit_value
        };
        act_s = pipe_action(bus.flush, bus.stall);
    end

    // Pipeline register; a $zero destination is passed through untouched.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            wb_r <= WB_BUBBLE;
        end else begin
            case (act_s)
                ACT_CAPTURE: wb_r <= mem_s;
                ACT_HOLD:    wb_r <= wb_r;
                ACT_FLUSH:   wb_r <= WB_BUBBLE;
                ACT_BUBBLE:  wb_r <= WB_BUBBLE;
                default:     wb_r <= WB_BUBBLE;
            endcase
        end
    end

    llbit_reg u_llbit (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.flush),
        .we    (wb_r.llbit_we),
        .din   (wb_r.llbit_value),
        .dout  (llbit_s)
    );

    // Forward a pending WB-stage LL write so SC in MEM sees it immediately.
    always_comb begin
        llbit_o_s = 1'b0;
        if (wb_r.llbit_we == WRITE_ENABLE) begin
            llbit_o_s = wb_r.llbit_value;
        end else begin
            llbit_o_s = llbit_s;
        end
    end

    assign bus.wb_wd          = wb_r.wd;
    assign bus.wb_wreg        = wb_r.wreg;
    assign bus.wb_wdata       = wb_r.wdata;
    assign bus.wb_whilo       = wb_r.whilo;
    assign bus.wb_hi          = wb_r.hi;
    assign bus.wb_lo          = wb_r.lo;
    assign bus.wb_llbit_we    = wb_r.llbit_we;
    assign bus.wb_llbit_value = wb_r.llbit_value;
    assign bus.llbit_o        = llbit_o_s;

endmodule

// File: tb/tb_mem_wb.sv
// Directed self-checking bench for mem_wb with a small regfile model on the WB port.
module tb_mem_wb;
    import mem_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] rf [32];

    mem_wb_if bus ();

    mem_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Regfile model: writes to r0 are suppressed here, not in mem_wb.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (bus.wb_wreg && bus.wb_wd != 5'd0) begin
            rf[bus.wb_wd] <= bus.wb_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wd"},     {27'd0, bus.wb_wd},          32'h0);
        check({tag, ".wreg"},   {31'd0, bus.wb_wreg},        32'h0);
        check({tag, ".wdata"},  bus.wb_wdata,                32'h0);
        check({tag, ".whilo"},  {31'd0, bus.wb_whilo},       32'h0);
        check({tag, ".hi"},     bus.wb_hi,                   32'h0);
        check({tag, ".lo"},     bus.wb_lo,                   32'h0);
        check({tag, ".ll_we"},  {31'd0, bus.wb_llbit_we},    32'h0);
        check({tag, ".ll_val"}, {31'd0, bus.wb_llbit_value}, 32'h0);
    endtask

    task automatic set_mem(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                           input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                           input logic llwe, input logic llval);
        bus.mem_wd          = wd;
        bus.mem_wreg        = wreg;
        bus.mem_wdata       = wdata;
        bus.mem_whilo       = whilo;
        bus.mem_hi          = hi;
        bus.mem_lo          = lo;
        bus.mem_llbit_we    = llwe;
        bus.mem_llbit_value = llval;
    endtask

    initial begin
        // Reset for two cycles with all MEM inputs high.
        bus.stall = 6'b000000;
        bus.flush = 1'b0;
        set_mem(5'h1f, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        check("reset.llbit_o", {31'd0, bus.llbit_o}, 32'h0);

        // Plain capture.
        rst = 1'b0;
        set_mem(5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("cap.wd",    {27'd0, bus.wb_wd},   32'd5);
        check("cap.wreg",  {31'd0, bus.wb_wreg}, 32'd1);
        check("cap.wdata", bus.wb_wdata,         32'hDEAD_BEEF);

        // Full stall holds despite new MEM data.
        bus.stall = 6'b110000;
        set_mem(5'd9, 1'b0, 32'h1111_1111, 1'b1, 32'h2222_2222, 32'h3333_3333, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("hold.wd",    {27'd0, bus.wb_wd},    32'd5);
            check("hold.wreg",  {31'd0, bus.wb_wreg},  32'd1);
            check("hold.wdata", bus.wb_wdata,          32'hDEAD_BEEF);
            check("hold.whilo", {31'd0, bus.wb_whilo}, 32'd0);
        end
        check("rf.r5", rf[5], 32'hDEAD_BEEF);

        // MEM stalled, WB free: bubble.
        bus.stall = 6'b010000;
        tick();
        check_all_zero("bubble");

        // LL write: forwarded on edge 1, stored on edge 2, cleared by flush on edge 3.
        bus.stall = 6'b000000;
        set_mem(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        check("ll1.we",      {31'd0, bus.wb_llbit_we}, 32'd1);
        check("ll1.llbit_o", {31'd0, bus.llbit_o},     32'd1);
        set_mem(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("ll2.we",      {31'd0, bus.wb_llbit_we}, 32'd0);
        check("ll2.llbit_o", {31'd0, bus.llbit_o},     32'd1);
        bus.flush = 1'b1;
        tick();
        check_all_zero("ll3");
        check("ll3.llbit_o", {31'd0, bus.llbit_o}, 32'd0);

        // Flush clears llbit even while a WB-stage LL write is pending.
        bus.flush = 1'b0;
        set_mem(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        set_mem(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        tick();
        check("llflush.llbit_o", {31'd0, bus.llbit_o}, 32'd0);

        // Flush combined with full stall behaves as flush.
        bus.flush = 1'b0;
        set_mem(5'd7, 1'b1, 32'h5555_AAAA, 1'b1, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b0, 1'b0);
        tick();
        check("pre.whilo", {31'd0, bus.wb_whilo}, 32'd1);
        check("pre.hi",    bus.wb_hi,             32'hAAAA_AAAA);
        bus.stall = 6'b110000;
        bus.flush = 1'b1;
        set_mem(5'd7, 1'b1, 32'h5555_AAAA, 1'b1, 32'h1234_5678, 32'hCCCC_CCCC, 1'b0, 1'b0);
        tick();
        check("fstall.whilo", {31'd0, bus.wb_whilo}, 32'd0);
        check("fstall.hi",    bus.wb_hi,             32'h0);
        check("fstall.lo",    bus.wb_lo,             32'h0);

        // $zero destination passes through; the regfile keeps r0 at zero.
        bus.stall = 6'b000000;
        bus.flush = 1'b0;
        set_mem(5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("r0.wd",    {27'd0, bus.wb_wd},   32'd0);
        check("r0.wreg",  {31'd0, bus.wb_wreg}, 32'd1);
        check("r0.wdata", bus.wb_wdata,         32'hFFFF_FFFF);
        tick();
        check("rf.r0", rf[0], 32'h0);

        // Reset during a full stall discards held data.
        set_mem(5'd3, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        bus.stall = 6'b110000;
        rst = 1'b1;
        tick();
        check_all_zero("rststall");
        rst = 1'b0;
        tick();
        check("rststall.hold_wdata", bus.wb_wdata, 32'h0);
        bus.stall = 6'b000000;
        tick();
        check("post.wdata", bus.wb_wdata, 32'h0BAD_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
